// File: rtl/crc_serial_engine.sv
// Serial CRC generate/check engine.
// A captured word is shifted MSB-first through a CRC_W-bit division register.
// In generate mode CRC_W zero bits are appended; in check mode the received CRC is appended.
// Each shifted bit is mirrored on ser_bit/ser_vld for the downstream serial stage.
module crc_serial_engine #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       CRC_W  = 3,
  parameter logic [CRC_W:0]    POLY   = 4'b1011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_err,
  output logic              ser_bit,
  output logic              ser_vld
);

  localparam int unsigned N     = DATA_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [N-1:0]       stream_q;
  logic [CRC_W-1:0]   rem_q;
  logic [CRC_W-1:0]   rem_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q;
  logic               shift_bit;

  // Next remainder after absorbing the current stream MSB.
  always_comb begin
    shift_bit = stream_q[N-1];
    rem_d     = {rem_q[CRC_W-2:0], shift_bit};
    if (rem_q[CRC_W-1]) begin
      rem_d = rem_d ^ POLY[CRC_W-1:0];
    end
  end

  // The stream register is only non-zero while shifting, but gate anyway so
  // ser_bit is cleanly 0 outside a frame.
  assign ser_bit = busy & shift_bit;
  assign ser_vld = busy;

  // Controller FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stream_q <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_out  <= '0;
      crc_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            stream_q <= {data_in, (mode ? crc_in : {CRC_W{1'b0}})};
            rem_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= mode;
            busy     <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          stream_q <= {stream_q[N-2:0], 1'b0};
          rem_q    <= rem_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            crc_out <= rem_d;
            crc_err <= mode_q & (|rem_d);
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine (DATA_W=8, CRC_W=3, POLY=1011).
module tb_crc_serial_engine;

  localparam int N = 11;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] data_in;
  logic [2:0] crc_in;
  logic       busy;
  logic       done;
  logic [2:0] crc_out;
  logic       crc_err;
  logic       ser_bit;
  logic       ser_vld;

  int checks = 0;
  int errors = 0;

  crc_serial_engine #(
    .DATA_W (8),
    .CRC_W  (3),
    .POLY   (4'b1011)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
    .crc_in  (crc_in),
    .busy    (busy),
    .done    (done),
    .crc_out (crc_out),
    .crc_err (crc_err),
    .ser_bit (ser_bit),
    .ser_vld (ser_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of {d, app} by long division with x^3+x+1.
  function automatic logic [2:0] crc_ref(input logic [7:0] d, input logic [2:0] app);
    logic [10:0] v;
    v = {d, app};
    for (int i = 10; i >= 3; i--) begin
      if (v[i]) v[i-:4] = v[i-:4] ^ 4'b1011;
    end
    return v[2:0];
  endfunction

  // Runs one frame; checks latency, busy/ser_vld, one-cycle done and result hold.
  task automatic do_frame(input logic m, input logic [7:0] d, input logic [2:0] c,
                          output logic [10:0] bits, output logic [2:0] co,
                          output logic ce);
    logic [2:0] prev_out;
    logic       prev_err;
    logic       vld_ok;
    logic       held_ok;
    @(negedge clk);
    prev_out = crc_out;
    prev_err = crc_err;
    mode = m; data_in = d; crc_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Changing inputs after capture must not disturb the frame.
    mode = ~m; data_in = ~d; crc_in = ~c;
    bits = '0; vld_ok = 1'b1; held_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!(busy === 1'b1 && ser_vld === 1'b1 && done === 1'b0)) vld_ok = 1'b0;
      if (crc_out !== prev_out || crc_err !== prev_err) held_ok = 1'b0;
      bits = {bits[9:0], ser_bit};
      @(negedge clk);
    end
    chk("frame_busy_vld", vld_ok, 1);
    chk("frame_result_held", held_ok, 1);
    chk("frame_done_latency", done, 1);
    chk("frame_busy_in_done", busy, 0);
    co = crc_out; ce = crc_err;
    @(negedge clk);
    chk("frame_done_one_cycle", done, 0);
    chk("frame_result_after", {crc_out, crc_err}, {co, ce});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    logic [2:0]  co;
    logic        ce;
    logic [2:0]  c;
    logic [7:0]  d;
    logic [10:0] cw;
    logic        flag;
    int          last;
    int          pulses;
    logic        prev_done;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; data_in = '0; crc_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, crc_out, crc_err, ser_bit, ser_vld}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {busy, done, crc_out, crc_err, ser_bit, ser_vld}, 0);

    // Generate A5
    do_frame(1'b0, 8'hA5, 3'b000, bits, co, ce);
    chk("gen_a5_ser_bits", bits, 11'b10100101000);
    chk("gen_a5_crc", co, 3'b101);
    chk("gen_a5_err", ce, 0);

    // Generate FF and 00
    do_frame(1'b0, 8'hFF, 3'b000, bits, co, ce);
    chk("gen_ff_crc", co, 3'b011);
    chk("gen_ff_err", ce, 0);
    do_frame(1'b0, 8'h00, 3'b000, bits, co, ce);
    chk("gen_00_crc", co, 3'b000);
    chk("gen_00_ser_bits", bits, 11'b0);
    do_frame(1'b0, 8'h02, 3'b000, bits, co, ce);
    chk("gen_02_crc", co, 3'b110);

    // Check mode, crc_in goes out on the serial stream too
    do_frame(1'b1, 8'hA5, 3'b101, bits, co, ce);
    chk("chk_a5_good_ser", bits, 11'b10100101101);
    chk("chk_a5_good_crc", co, 3'b000);
    chk("chk_a5_good_err", ce, 0);
    do_frame(1'b1, 8'hA5, 3'b100, bits, co, ce);
    chk("chk_a5_bad_crc", co, 3'b001);
    chk("chk_a5_bad_err", ce, 1);

    // Asynchronous reset mid-frame
    @(negedge clk);
    mode = 1'b0; data_in = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", {busy, done, crc_out, crc_err, ser_bit, ser_vld}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
    end
    chk("rst_no_resume", flag, 0);
    do_frame(1'b0, 8'hFF, 3'b000, bits, co, ce);
    chk("rst_clean_ser", bits, 11'b11111111000);
    chk("rst_clean_crc", co, 3'b011);

    // start held high, data_in toggled while busy
    @(negedge clk);
    mode = 1'b0; data_in = 8'hA5; crc_in = 3'b000; start = 1'b1;
    last = -1; pulses = 0; prev_done = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (prev_done) chk("hold_done_width", done, 0);
      if (done === 1'b1) begin
        pulses++;
        chk("hold_crc", {crc_out, crc_err}, {3'b101, 1'b0});
        if (last >= 0) chk("hold_period", cyc - last, 13);
        last = cyc;
      end
      prev_done = done;
      data_in = busy ? 8'($urandom) : 8'hA5;
    end
    start = 1'b0;
    chk("hold_pulses", pulses, 4);
    for (int i = 0; i < 30 && (busy === 1'b1 || done === 1'b1); i++) @(negedge clk);
    chk("hold_drained", {busy, done}, 0);

    // Model-driven words: generate, check good, check single-bit corruption
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      c = crc_ref(d, 3'b000);
      do_frame(1'b0, d, 3'b000, bits, co, ce);
      chk("rnd_gen_crc", co, c);
      do_frame(1'b1, d, c, bits, co, ce);
      chk("rnd_chk_good", {co, ce}, {3'b000, 1'b0});
      cw = {d, c} ^ (11'b1 << $urandom_range(0, 10));
      do_frame(1'b1, cw[10:3], cw[2:0], bits, co, ce);
      chk("rnd_chk_flip_err", ce, 1);
      chk("rnd_chk_flip_rem", co, crc_ref(cw[10:3], cw[2:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
